// File: rtl/ahb_sram_pkg.sv
// Shared encodings, FSM state type and byte-enable helper for the AHB SRAM slave.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// 1R1W synchronous word array with byte-write enables and a one-cycle registered read.
module ahb_sram_array #(
  parameter int WORDS = 16384,
  parameter int AW    = 14
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read port register, only updated by a read so the value holds between reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0000_0000;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with two-cycle ERROR response and write-to-read forwarding.
// Optional data-phase wait states are built when AHB_SRAM_WS_EN is defined.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk_i,
  input  logic        hresetn_i,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [3:0]  hprot_i,
  input  logic        hmastlock_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  state_e        state_q, state_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic          wr_q;
  logic [3:0]    fwd_be_q;
  logic [31:0]   fwd_data_q;
  logic          accept_s, legal_s, stall_s, last_s, re_s, we_s, fwd_s;
  logic [AW-1:0] word_s;
  logic [31:0]   arr_rdata_s, rdata_s;
  logic          unused_s;

  assign unused_s = ^{hburst_i, hprot_i, hmastlock_i, 4'(WAIT_STATES)};
  assign word_s   = haddr_i[AW+1:2];
  // ERR1 and wait stalls hold hreadyout low, so no accept can sneak in there
  assign accept_s = hsel_i & hready_i & htrans_i[1] & hreadyout_q;

  // Legality: in-range address, supported size, natural alignment
  always_comb begin
    legal_s = 1'b1;
    if ({1'b0, haddr_i} >= MEM_BYTES) begin
      legal_s = 1'b0;
    end else if (hsize_i > HSIZE_WORD) begin
      legal_s = 1'b0;
    end else if ((hsize_i == HSIZE_WORD) && (haddr_i[1:0] != 2'b00)) begin
      legal_s = 1'b0;
    end else if ((hsize_i == HSIZE_HALF) && haddr_i[0]) begin
      legal_s = 1'b0;
    end else begin
      legal_s = 1'b1;
    end
  end

`ifdef AHB_SRAM_WS_EN
  localparam logic OK_READY = 1'b0;
  logic [3:0] wcnt_q;

  // Wait counter loaded on every legal accept
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      wcnt_q <= 4'd0;
    end else if (accept_s && legal_s) begin
      wcnt_q <= 4'(WAIT_STATES);
    end else if (wcnt_q != 4'd0) begin
      wcnt_q <= wcnt_q - 4'd1;
    end else begin
      wcnt_q <= wcnt_q;
    end
  end

  assign stall_s = (wcnt_q != 4'd0);
  assign last_s  = (wcnt_q == 4'd1);
`else
  localparam logic OK_READY = 1'b1;
  assign stall_s = 1'b0;
  assign last_s  = 1'b0;
`endif

  // Next state/outputs at an accept point (IDLE, ERR2, completing DATA)
  always_comb begin
    state_d     = ST_IDLE;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    if (!accept_s) begin
      state_d     = ST_IDLE;
      hreadyout_d = 1'b1;
      hresp_d     = HRESP_OKAY;
    end else if (legal_s) begin
      state_d     = ST_DATA;
      hreadyout_d = OK_READY;
      hresp_d     = HRESP_OKAY;
    end else begin
      state_d     = ST_ERR1;
      hreadyout_d = 1'b0;
      hresp_d     = HRESP_ERROR;
    end
  end

  // Transfer FSM with registered handshake outputs
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        ST_DATA: begin
          if (stall_s) begin
            state_q     <= ST_DATA;
            hreadyout_q <= last_s;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
          end
        end
        ST_IDLE, ST_ERR2: begin
          state_q     <= state_d;
          hreadyout_q <= hreadyout_d;
          hresp_q     <= hresp_d;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Address-phase capture for the following data phase
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      addr_q <= '0;
      be_q   <= 4'b0000;
      wr_q   <= 1'b0;
    end else if (accept_s && legal_s) begin
      addr_q <= word_s;
      be_q   <= byte_en(hsize_i, haddr_i[1:0]);
      wr_q   <= hwrite_i;
    end else begin
      addr_q <= addr_q;
      be_q   <= be_q;
      wr_q   <= wr_q;
    end
  end

  assign re_s  = accept_s & legal_s & ~hwrite_i;
  assign we_s  = (state_q == ST_DATA) & wr_q & hreadyout_q;
  assign fwd_s = re_s & we_s & (word_s == addr_q);

  // Array reads old data on the commit edge, so remember the bytes being written
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0000_0000;
    end else if (re_s) begin
      fwd_be_q   <= fwd_s ? be_q : 4'b0000;
      fwd_data_q <= hwdata_i;
    end else begin
      fwd_be_q   <= fwd_be_q;
      fwd_data_q <= fwd_data_q;
    end
  end

  ahb_sram_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk_i   (hclk_i),
    .rst_ni  (hresetn_i),
    .re_i    (re_s),
    .raddr_i (word_s),
    .rdata_o (arr_rdata_s),
    .we_i    (we_s),
    .waddr_i (addr_q),
    .be_i    (be_q),
    .wdata_i (hwdata_i)
  );

  // Per-lane merge of forwarded write bytes over array data
  always_comb begin
    rdata_s = arr_rdata_s;
    for (int b = 0; b < 4; b++) begin
      rdata_s[8*b +: 8] = fwd_be_q[b] ? fwd_data_q[8*b +: 8] : arr_rdata_s[8*b +: 8];
    end
  end

  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = rdata_s;

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter MEM_WORDS, default 16384, gives the array depth in 32-bit words; valid byte range is 0 to MEM_WORDS*4-1.
REQ-002 Parameter WAIT_STATES, default 1, range 1..15, gives the data-phase stall cycles per OKAY transfer; it is used only with AHB_SRAM_WS_EN.
REQ-003 hclk_i  in  1  clock; all state updates on the rising edge.
REQ-004 hresetn_i  in  1  asynchronous active-low reset.
REQ-005 hsel_i  in  1  slave select.
REQ-006 haddr_i  in  32  byte address.
REQ-007 htrans_i  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hwrite_i  in  1  1 = write.
REQ-009 hsize_i  in  3  transfer size: 000 byte, 001 half, 010 word.
REQ-010 hburst_i, hprot_i, hmastlock_i  in  3/4/1  accepted and ignored.
REQ-011 hwdata_i  in  32  write data, valid in the data phase.
REQ-012 hready_i  in  1  bus-level ready (previous transfer completing).
REQ-013 hreadyout_o  out  1  slave ready.
REQ-014 hresp_o  out  1  0 = OKAY, 1 = ERROR.
REQ-015 hrdata_o  out  32  read data.

Function
REQ-016 A transfer is accepted when hsel_i & hready_i & htrans_i[1] are all 1; haddr_i, hsize_i and hwrite_i are latched on that edge.
REQ-017 IDLE and BUSY transfers, or hsel_i=0, get a zero-wait OKAY response with no array access.
REQ-018 The FSM has states IDLE, DATA, ERR1 and ERR2.
REQ-019 IDLE goes to DATA on a legal accept and to ERR1 on an illegal accept.
REQ-020 DATA completes when the wait counter is 0, then goes to DATA, ERR1 or IDLE depending on the next accept.
REQ-021 ERR1 always goes to ERR2.
REQ-022 ERR2 behaves as the IDLE accept point.
REQ-023 A transfer is illegal if: byte address >= MEM_WORDS*4; hsize_i > 010; a word access has haddr[1:0] != 0; or a half-word access has haddr[0] != 0.
REQ-024 An illegal transfer gets a two-cycle ERROR: ERR1 drives hreadyout_o=0, hresp_o=1; ERR2 drives hreadyout_o=1, hresp_o=1. There is no array access and hrdata_o holds its value.
REQ-025 An address phase presented during ERR1 is ignored, because hready is low.
REQ-026 Byte enables: byte = 4'b0001 << haddr[1:0]; half = 4'b0011 when haddr[1]=0, else 4'b1100; word = 4'b1111.
REQ-027 The read access is issued in the address-phase cycle; hrdata_o is valid in the data-phase cycle where hreadyout_o=1 and is held until the next completed read.
REQ-028 Write data is sampled from hwdata_i and committed with the byte enables on the edge ending the data phase (hreadyout_o=1).
REQ-029 Read-after-write to the same word (write data phase coincides with the next read address phase): enabled write bytes are forwarded into the read data and the other bytes come from the array.
REQ-030 Lanes not selected by a byte or half-word read return the array contents unmodified.
REQ-031 hresp_o=0 in IDLE and DATA.

Reset
REQ-032 On reset assertion: hreadyout_o=1, hresp_o=0, hrdata_o=0, FSM=IDLE, wait counter=0.
REQ-033 On reset assertion, a pending write is dropped and an in-flight error sequence is aborted.
REQ-034 Array contents are not reset.
REQ-035 Reset deassertion takes effect on the next clock edge; the first accept is possible on the first edge after deassertion.

Configuration
REQ-036 Macro AHB_SRAM_WS_EN defined: on each legal accept the wait counter loads WAIT_STATES; hreadyout_o=0 while the counter is nonzero; the counter decrements each cycle.
REQ-037 With AHB_SRAM_WS_EN, read data is registered at array output and held through the stall.
REQ-038 AHB_SRAM_WS_EN undefined: the wait counter is absent and all OKAY transfers are zero-wait.
REQ-039 Error response timing is identical with and without AHB_SRAM_WS_EN.

Structure
REQ-040 Package ahb_sram_pkg holds the htrans/hsize/hresp encodings, the FSM state enum and a byte-enable function.
REQ-041 One sub-module, ahb_sram_array: a 1R1W synchronous array with byte-write enables and one-cycle read latency, instantiated once.

Verification
REQ-042 Word write 0xDEADBEEF at 0x100, then word read at 0x100 -> hrdata_o=0xDEADBEEF, hresp_o=0; zero-wait without the macro, 1 stall with WAIT_STATES=1.
REQ-043 Byte write 0xAA at 0x103 over 0x11223344, then word read -> 0xAA223344.
REQ-044 Back-to-back: write 0x55667788 at 0x200 immediately followed by read of 0x200 -> forwarded 0x55667788 with no extra stall.
REQ-045 Word read at 0x102 -> ERR1 (hreadyout_o=0, hresp_o=1) then ERR2 (1,1); the array is unchanged; the next NONSEQ accepted in ERR2 completes OKAY.
REQ-046 Read at MEM_WORDS*4 -> two-cycle ERROR; hsize_i=011 -> two-cycle ERROR.
REQ-047 hresetn_i pulsed low during a write stall -> outputs reach reset values immediately and the target word is unchanged.
